// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and the TX state enum.
// Kept separate so a future receiver can reuse them.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake and serial line between a producer and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic [DATA_BITS-1:0] data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx;

  modport master (output start, data, input tx_busy, tx_done, tx);
  modport slave  (input start, data, output tx_busy, tx_done, tx);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled and flags the terminal count.
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
//   state    | meaning
//   ST_IDLE  | line high, waiting for start
//   ST_START | start bit (tx=0)
//   ST_DATA  | data bits, shift register LSB out
//   ST_PAR   | parity bit (skipped when PARITY=PAR_NONE)
//   ST_STOP  | stop bit(s), tx=1
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic            clk,
  input logic            reset,
  uart_tx_cfg_if.slave   bus
);
  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_accept;
  logic                 w_tick;

  assign w_accept = (r_state == ST_IDLE) && bus.start;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (w_accept),
    .en    (r_busy),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.data;
            r_par     <= (PARITY == PAR_ODD) ? ~(^bus.data) : ^bus.data;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              // Parity was computed at acceptance, so later data changes cannot leak in.
              if (PARITY != PAR_NONE) begin
                r_tx    <= r_par;
                r_state <= ST_PAR;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        ST_PAR: begin
          if (w_tick) begin
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_STOP) begin
              r_bit_cnt <= '0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench: four transmitter configurations checked cycle by cycle against a frame model.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       s_start [4];
  logic [8:0] s_data  [4];
  logic       w_tx    [4];
  logic       w_busy  [4];
  logic       w_done  [4];

  localparam int CD [4] = '{4, 4, 4, 3};
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PR [4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 1, 1, 2};

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if_d ();

  assign if_a.start = s_start[0];
  assign if_a.data  = s_data[0][7:0];
  assign if_b.start = s_start[1];
  assign if_b.data  = s_data[1][7:0];
  assign if_c.start = s_start[2];
  assign if_c.data  = s_data[2][7:0];
  assign if_d.start = s_start[3];
  assign if_d.data  = s_data[3][6:0];

  assign w_tx[0] = if_a.tx;  assign w_busy[0] = if_a.tx_busy;  assign w_done[0] = if_a.tx_done;
  assign w_tx[1] = if_b.tx;  assign w_busy[1] = if_b.tx_busy;  assign w_done[1] = if_b.tx_done;
  assign w_tx[2] = if_c.tx;  assign w_busy[2] = if_c.tx_busy;  assign w_done[2] = if_c.tx_done;
  assign w_tx[3] = if_d.tx;  assign w_busy[3] = if_d.tx_busy;  assign w_done[3] = if_d.tx_done;

  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (.clk(clk), .reset(reset), .bus(if_a));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (.clk(clk), .reset(reset), .bus(if_c));
  uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_d (.clk(clk), .reset(reset), .bus(if_d));

  typedef struct {
    logic  tx;
    logic  busy;
    logic  done;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic int frame_len(int d);
    return CD[d] * (1 + DB[d] + ((PR[d] != 0) ? 1 : 0) + SB[d]);
  endfunction

  // Expected line level j cycles after the accepting edge.
  function automatic logic model_bit(int d, logic [8:0] w, int j);
    int   idx;
    logic p;
    idx = j / CD[d];
    p   = 1'b0;
    for (int i = 0; i < DB[d]; i++) p = p ^ w[i];
    if (PR[d] == 1) p = ~p;
    if (idx == 0) return 1'b0;
    if (idx <= DB[d]) return w[idx-1];
    if (PR[d] != 0 && idx == DB[d] + 1) return p;
    return 1'b1;
  endfunction

  task automatic push_frame(input int d, input logic [8:0] w, input int n, input string tag);
    exp_t e;
    int   f;
    f = frame_len(d);
    for (int j = 0; j < n; j++) begin
      e.tag = tag;
      if (j < f) begin
        e.tx = model_bit(d, w, j); e.busy = 1'b1; e.done = 1'b0;
      end else begin
        e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input string tag, input int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.tag = tag; e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic check_pop(input int d);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_empty dut%0d observed no expectation, required one", d);
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (w_tx[d] === e.tx) else begin
      miscompares++;
      $error("FAIL %s dut%0d tx observed %0b expected %0b", e.tag, d, w_tx[d], e.tx);
    end
    vectors++;
    assert (w_busy[d] === e.busy) else begin
      miscompares++;
      $error("FAIL %s dut%0d tx_busy observed %0b expected %0b", e.tag, d, w_busy[d], e.busy);
    end
    vectors++;
    assert (w_done[d] === e.done) else begin
      miscompares++;
      $error("FAIL %s dut%0d tx_done observed %0b expected %0b", e.tag, d, w_done[d], e.done);
    end
  endtask

  task automatic cycle_check(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check_pop(d);
    end
  endtask

  // One frame; data is scrambled after acceptance and start optionally pulsed mid-frame.
  task automatic send(input int d, input logic [8:0] w, input string tag, input int pulse_at);
    int f;
    f = frame_len(d);
    @(negedge clk);
    s_start[d] = 1'b1;
    s_data[d]  = w;
    push_frame(d, w, f + 1, tag);
    push_idle({tag, "_after"}, 2);
    @(posedge clk); #1;
    check_pop(d);
    for (int j = 1; j <= f + 2; j++) begin
      @(negedge clk);
      s_start[d] = (j == pulse_at);
      s_data[d]  = ~w;
      @(posedge clk); #1;
      check_pop(d);
    end
    @(negedge clk);
    s_start[d] = 1'b0;
  endtask

  initial begin
    int f;
    logic [8:0] w1, w2;
    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      s_start[d] = 1'b0;
      s_data[d]  = 9'h000;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      push_idle("reset", 1);
      check_pop(d);
    end
    @(negedge clk);
    reset = 1'b0;

    repeat (50) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        push_idle("idle50", 1);
        check_pop(d);
      end
    end

    send(0, 9'h0A5, "a5_8n1", 10);
    send(1, 9'h001, "even_01", 0);
    send(2, 9'h001, "odd_01", 0);
    send(3, 9'h07F, "d7s2_7f", 5);
    send(0, 9'h03C, "3c_8n1", 0);
    send(1, 9'h0B7, "even_b7", 20);
    send(2, 9'h0FF, "odd_ff", 0);
    send(3, 9'h055, "d7s2_55", 0);

    // Start held high through the done cycle chains a second frame with the new word.
    f  = frame_len(0);
    w1 = 9'h0C3;
    w2 = 9'h05E;
    @(negedge clk);
    s_start[0] = 1'b1;
    s_data[0]  = w1;
    push_frame(0, w1, f + 1, "chain1");
    push_frame(0, w2, f + 1, "chain2");
    push_idle("chain_after", 2);
    @(posedge clk); #1;
    check_pop(0);
    for (int j = 1; j <= f; j++) begin
      @(negedge clk);
      s_data[0] = w2;
      @(posedge clk); #1;
      check_pop(0);
    end
    for (int j = f + 1; j <= 2 * f + 3; j++) begin
      @(negedge clk);
      if (j >= f + 2) begin
        s_start[0] = 1'b0;
        s_data[0]  = 9'($urandom_range(0, 255));
      end else begin
        s_data[0] = w2;
      end
      @(posedge clk); #1;
      check_pop(0);
    end

    // Reset on cycle 15 of a frame, with start also high to show reset wins.
    @(negedge clk);
    s_start[0] = 1'b1;
    s_data[0]  = 9'h0F0;
    push_frame(0, 9'h0F0, 15, "pre_rst");
    @(posedge clk); #1;
    check_pop(0);
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      s_start[0] = 1'b0;
      @(posedge clk); #1;
      check_pop(0);
    end
    @(negedge clk);
    reset      = 1'b1;
    s_start[0] = 1'b1;
    push_idle("rst_abort", 1);
    @(posedge clk); #1;
    check_pop(0);
    @(negedge clk);
    reset      = 1'b0;
    s_start[0] = 1'b0;
    push_idle("rst_idle", 3);
    cycle_check(0, 3);
    send(0, 9'h05A, "post_rst", 0);

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL sb_leftover observed %0d entries, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
